// File: rtl/oam_dma.sv
// OAM DMA engine and CPU-bus gate in front of the MMU; owns register $FF46.
// Optional macro OAM_DMA_BUS_CONFLICT_EN: blocked reads return the last fetched DMA byte.
module oam_dma #(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int STARTUP_CYCLES  = 4,
    parameter int OAM_BYTES       = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_read_en,
    input  logic        cpu_write_en,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_wait,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_read_en,
    output logic        mem_write_en,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic        dma_active
);

    // state | meaning
    // IDLE  | bus pass-through, only $FF46 intercepted
    // START | startup delay after a $FF46 write
    // XFER  | copying; one slot every CYCLES_PER_BYTE cycles at phase 0
    typedef enum logic [1:0] {IDLE, START, XFER} state_t;

    localparam int PW = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
    localparam int CW = $clog2(STARTUP_CYCLES + 1);
    localparam logic [15:0]   DMA_REG    = 16'hFF46;
    localparam logic [PW-1:0] PHASE_LAST = PW'(CYCLES_PER_BYTE - 1);
    localparam logic [7:0]    IDX_LAST   = 8'(OAM_BYTES - 1);
    localparam logic [CW-1:0] CNT_LOAD   = CW'(STARTUP_CYCLES - 1);

    state_t        state, state_nxt;
    logic [7:0]    src_reg, src_nxt;
    logic [7:0]    idx, idx_nxt;
    logic [PW-1:0] phase, phase_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic       wr, rd, is_reg, high, active, slot, reg_wr;
    logic [7:0] eff, blocked_byte;

    assign wr     = cpu_write_en;
    assign rd     = cpu_read_en & ~cpu_write_en;
    assign is_reg = (cpu_addr == DMA_REG);
    assign high   = (cpu_addr[15:8] == 8'hFF);
    assign active = (state != IDLE);
    assign slot   = (state == XFER) && (phase == '0);
    // A slot cycle stalls every high-page request, $FF46 included; the CPU retries.
    assign reg_wr = wr & is_reg & ~slot;
    assign eff    = (src_reg >= 8'hE0) ? (src_reg - 8'h20) : src_reg;

`ifdef OAM_DMA_BUS_CONFLICT_EN
    logic [7:0] conflict_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_byte <= 8'hFF;
        end else if (slot) begin
            conflict_byte <= mem_rdata;
        end
    end

    assign blocked_byte = conflict_byte;
`else
    assign blocked_byte = 8'hFF;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            src_reg <= 8'hFF;
            idx     <= '0;
            phase   <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            src_reg <= src_nxt;
            idx     <= idx_nxt;
            phase   <= phase_nxt;
            cnt     <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        src_nxt   = src_reg;
        idx_nxt   = idx;
        phase_nxt = phase;
        cnt_nxt   = cnt;
        if (reg_wr) begin
            src_nxt   = cpu_wdata;
            state_nxt = START;
            idx_nxt   = '0;
            phase_nxt = '0;
            cnt_nxt   = CNT_LOAD;
        end else begin
            case (state)
                START: begin
                    if (cnt == '0) begin
                        state_nxt = XFER;
                        idx_nxt   = '0;
                        phase_nxt = '0;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                XFER: begin
                    if (phase == PHASE_LAST) begin
                        phase_nxt = '0;
                        if (idx == IDX_LAST) begin
                            state_nxt = IDLE;
                            idx_nxt   = '0;
                        end else begin
                            idx_nxt = idx + 8'd1;
                        end
                    end else begin
                        phase_nxt = phase + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_addr     = cpu_addr;
        mem_wdata    = cpu_wdata;
        mem_read_en  = rd;
        mem_write_en = wr;
        cpu_rdata    = mem_rdata;
        cpu_wait     = 1'b0;
        oam_addr     = idx;
        oam_wdata    = mem_rdata;
        oam_we       = 1'b0;
        dma_active   = active;
        if (is_reg) begin
            mem_read_en  = 1'b0;
            mem_write_en = 1'b0;
            cpu_rdata    = src_reg;
        end
        if (reset) begin
            dma_active = 1'b0;
        end else if (slot) begin
            mem_addr     = {eff, idx};
            mem_read_en  = 1'b1;
            mem_write_en = 1'b0;
            oam_we       = 1'b1;
            if (high) begin
                cpu_wait = rd | wr;
            end else begin
                cpu_rdata = blocked_byte;
            end
        end else if (active && !high) begin
            mem_read_en  = 1'b0;
            mem_write_en = 1'b0;
            cpu_rdata    = blocked_byte;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: OAM write scoreboard plus directed bus-gating checks.
// Define OAM_DMA_BUS_CONFLICT_EN for both bench and RTL to check the conflict-byte variant.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_read_en;
    logic        cpu_write_en;
    logic [7:0]  cpu_rdata;
    logic        cpu_wait;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [7:0]  mem_rdata;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic        dma_active;

    oam_dma dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_read_en(cpu_read_en), .cpu_write_en(cpu_write_en),
        .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_rdata(mem_rdata),
        .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we),
        .dma_active(dma_active)
    );

    always #5 clk = ~clk;

    // Memory image: page $C1 holds byte i at offset i; other pages differ by a page xor.
    function automatic logic [7:0] mdl(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hC1;
    endfunction

    assign mem_rdata = mdl(mem_addr);

    typedef struct {
        int          cyc;
        logic [7:0]  oa;
        logic [7:0]  od;
        logic [15:0] ma;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   we_cnt = 0;
    int   act_cnt = 0;

    function automatic void chk(input string n, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", n, got, want, cyc);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dma_active) act_cnt++;
        if (oam_we) begin
            we_cnt++;
            if (q.size() == 0) begin
                chk("unexpected_oam_we", 32'(oam_addr), 32'hFFFF);
            end else begin
                mon_e = q.pop_front();
                chk("slot_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("oam_addr", 32'(oam_addr), 32'(mon_e.oa));
                chk("oam_wdata", 32'(oam_wdata), 32'(mon_e.od));
                chk("slot_mem_addr", 32'(mem_addr), 32'(mon_e.ma));
                chk("slot_mem_read_en", 32'(mem_read_en), 32'd1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
        cpu_read_en  = r;
        cpu_write_en = w;
        cpu_addr     = a;
        cpu_wdata    = d;
    endtask

    task automatic idle_bus();
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic goto(input int t);
        while (cyc < t) step();
    endtask

    task automatic start_dma(input logic [7:0] src, output int c);
        drive(1'b0, 1'b1, 16'hFF46, src);
        c = cyc;
        #1;
        chk("ff46_write_not_forwarded", 32'(mem_write_en), 32'd0);
        step();
        idle_bus();
    endtask

    task automatic push_exp(input int c, input logic [7:0] page, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.cyc = c + 5 + 4 * k;
            e.oa  = 8'(k);
            e.ma  = {page, 8'(k)};
            e.od  = mdl(e.ma);
            q.push_back(e);
        end
    endtask

    task automatic wait_idle(input int bound, output int endc);
        int i = 0;
        while (dma_active && i < bound) begin
            step();
            i++;
        end
        endc = cyc;
        if (dma_active) chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c2, e;
        logic [7:0] blocked_exp;
        reset = 1'b1;
        idle_bus();
        step();
        chk("rst_dma_active", 32'(dma_active), 32'd0);
        chk("rst_oam_we", 32'(oam_we), 32'd0);
        chk("rst_cpu_wait", 32'(cpu_wait), 32'd0);
        step();
        reset = 1'b0;

        // $FF46 readback, and idle pass-through with write priority
        drive(1'b1, 1'b0, 16'hFF46, 8'h00);
        #1;
        chk("ff46_read_reset", 32'(cpu_rdata), 32'hFF);
        chk("ff46_read_no_mem", 32'(mem_read_en), 32'd0);
        step();
        drive(1'b1, 1'b1, 16'hC000, 8'h5A);
        #1;
        chk("idle_wr_prio_we", 32'(mem_write_en), 32'd1);
        chk("idle_wr_prio_re", 32'(mem_read_en), 32'd0);
        chk("idle_wdata", 32'(mem_wdata), 32'h5A);
        step();
        drive(1'b1, 1'b0, 16'hC005, 8'h00);
        #1;
        chk("idle_read_rdata", 32'(cpu_rdata), 32'h04);
        chk("idle_read_en", 32'(mem_read_en), 32'd1);
        step();
        start_dma(8'h80, c);
        drive(1'b1, 1'b0, 16'hFF46, 8'h00);
        #1;
        chk("ff46_read_80", 32'(cpu_rdata), 32'h80);
        chk("ff46_read80_no_mem", 32'(mem_read_en), 32'd0);
        chk("dma_active_after_write", 32'(dma_active), 32'd1);
        step();
        idle_bus();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("abort_before_slot", 32'(dma_active), 32'd0);

        // Full copy from $C100 with gating probes
        step();
        act_cnt = 0;
        we_cnt = 0;
        start_dma(8'hC1, c);
        push_exp(c, 8'hC1, 160);
        goto(c + 2);
        drive(1'b1, 1'b0, 16'hC000, 8'h00);
        #1;
        chk("blocked_read_start", 32'(cpu_rdata), 32'hFF);
        chk("blocked_read_no_mem", 32'(mem_read_en), 32'd0);
        chk("blocked_read_wait", 32'(cpu_wait), 32'd0);
        goto(c + 3);
        drive(1'b0, 1'b1, 16'hC000, 8'h33);
        #1;
        chk("blocked_write", 32'(mem_write_en), 32'd0);
        goto(c + 6);
        drive(1'b1, 1'b0, 16'hFF80, 8'h00);
        #1;
        chk("hi_nonslot_wait", 32'(cpu_wait), 32'd0);
        chk("hi_nonslot_addr", 32'(mem_addr), 32'hFF80);
        chk("hi_nonslot_rdata", 32'(cpu_rdata), 32'hBE);
        goto(c + 9);
        #1;
        chk("hi_slot_wait", 32'(cpu_wait), 32'd1);
        goto(c + 10);
        drive(1'b1, 1'b0, 16'hC000, 8'h00);
`ifdef OAM_DMA_BUS_CONFLICT_EN
        blocked_exp = 8'h01;
`else
        blocked_exp = 8'hFF;
`endif
        #1;
        chk("blocked_read_after_slots", 32'(cpu_rdata), 32'(blocked_exp));
        goto(c + 11);
        idle_bus();
        wait_idle(800, e);
        chk("dma_end_cycle", 32'(e), 32'(c + 645));
        chk("dma_active_cycles", 32'(act_cnt), 32'd644);
        chk("oam_we_count", 32'(we_cnt), 32'd160);
        chk("queue_empty_1", 32'(q.size()), 32'd0);

        // Echo alias: $E2 copies from $C200
        step();
        start_dma(8'hE2, c);
        push_exp(c, 8'hC2, 160);
        wait_idle(800, e);
        chk("echo_end_cycle", 32'(e), 32'(c + 645));
        chk("queue_empty_2", 32'(q.size()), 32'd0);

        // Restart at idx 50 with $D0
        step();
        we_cnt = 0;
        start_dma(8'hC1, c);
        push_exp(c, 8'hC1, 51);
        goto(c + 206);
        start_dma(8'hD0, c2);
        push_exp(c2, 8'hD0, 160);
        wait_idle(900, e);
        chk("restart_end_cycle", 32'(e), 32'(c + 206 + 645));
        chk("restart_we_count", 32'(we_cnt), 32'd211);
        chk("queue_empty_3", 32'(q.size()), 32'd0);

        // Reset in the idx 20 slot
        step();
        start_dma(8'hC1, c);
        push_exp(c, 8'hC1, 20);
        goto(c + 85);
        reset = 1'b1;
        #1;
        chk("rst_mid_oam_we", 32'(oam_we), 32'd0);
        chk("rst_mid_active", 32'(dma_active), 32'd0);
        step();
        reset = 1'b0;
        drive(1'b1, 1'b0, 16'hFF46, 8'h00);
        #1;
        chk("post_rst_active", 32'(dma_active), 32'd0);
        chk("post_rst_ff46", 32'(cpu_rdata), 32'hFF);
        chk("post_rst_oam_we", 32'(oam_we), 32'd0);
        idle_bus();
        for (int i = 0; i < 20; i++) step();
        chk("queue_empty_4", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
